vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock. Drives the current pixel coordinates (DrawX, DrawY) to color_mapper and takes its combinational RGB back in the same pixel slot. Registers that RGB together with HS/VS/BLANK so the DAC receives aligned outputs. Also issues a one-cycle frame_tick at end of the visible frame, which the game-object motion logic uses to advance one step per frame.

---
 rtl/vga_timing_pkg.sv | 21 ++
 rtl/vga_pix_div.sv | 45 ++++
 rtl/vga_timing_gen.sv | 124 ++++++++++++
 tb/tb_vga_timing_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and the coordinate type used by
// vga_timing_gen, color_mapper and the game-object motion blocks.
package vga_timing_pkg;

  localparam int unsigned COORD_W   = 11;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;
  localparam int unsigned CLK_DIV   = 2;

  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   pix_en  : high on the last system-clock cycle of every pixel slot
//   vga_clk : registered pixel clock, high for the second half of each slot
module vga_pix_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en,
  output logic vga_clk
);
  import vga_timing_pkg::*;

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  if ((CLK_DIV < 2) || (CLK_DIV % 2 != 0)) begin : g_bad_div
    $error("vga_pix_div: CLK_DIV must be even and at least 2");
  end

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;

  always_comb begin
    div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;
  end

  assign pix_en = (div == DIV_LAST);

  // vga_clk is registered from the next divider value so it tracks div
  // without lag: it rises mid-slot, away from the output-register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div     <= '0;
      vga_clk <= 1'b0;
    end else begin
      div     <= div_nxt;
      vga_clk <= (div_nxt >= DIV_HALF);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with registered, mutually aligned DAC outputs.
//   Clk, Reset_n            : system clock, asynchronous active-low reset
//   Red_in/Green_in/Blue_in : color_mapper colour for the current DrawX/DrawY
//   DrawX, DrawY            : live pixel column/line counters (incl. blanking)
//   VGA_R/G/B               : registered colour, 0 while blanked
//   VGA_HS, VGA_VS          : registered active-low syncs
//   VGA_BLANK_N             : registered, high in the visible region
//   VGA_SYNC_N              : tied low
//   VGA_CLK                 : pixel clock to the DAC
//   frame_tick              : one-Clk pulse after the last visible pixel
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int unsigned H_FP      = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP      = vga_timing_pkg::H_BP,
  parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int unsigned V_FP      = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP      = vga_timing_pkg::V_BP,
  parameter int unsigned CLK_DIV   = vga_timing_pkg::CLK_DIV
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [7:0]             Red_in,
  input  logic [7:0]             Green_in,
  input  logic [7:0]             Blue_in,
  output vga_timing_pkg::coord_t DrawX,
  output vga_timing_pkg::coord_t DrawY,
  output logic [7:0]             VGA_R,
  output logic [7:0]             VGA_G,
  output logic [7:0]             VGA_B,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   VGA_BLANK_N,
  output logic                   VGA_SYNC_N,
  output logic                   VGA_CLK,
  output logic                   frame_tick
);
  import vga_timing_pkg::*;

  localparam int unsigned H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if ((H_TOT >= (1 << COORD_W)) || (V_TOT >= (1 << COORD_W))) begin : g_bad_total
    $error("vga_timing_gen: H/V totals must be below 2048");
  end

  localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t H_VIS_LAST = coord_t'(H_VISIBLE - 1);
  localparam coord_t V_VIS_LAST = coord_t'(V_VISIBLE - 1);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  logic   pix_en;
  coord_t hc;
  coord_t vc;
  logic   visible;
  logic   hs_raw;
  logic   vs_raw;

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .pix_en  (pix_en),
    .vga_clk (VGA_CLK)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_en) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

  always_comb begin
    visible = (hc < H_VIS) && (vc < V_VIS);
    hs_raw  = !((hc >= HS_START) && (hc < HS_END));
    vs_raw  = !((vc >= VS_START) && (vc < VS_END));
  end

  // Everything sampled here comes from the pixel that is ending, so RGB,
  // syncs and blanking leave on the same edge with one pixel of latency.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= pix_en && (hc == H_VIS_LAST) && (vc == V_VIS_LAST);
      if (pix_en) begin
        VGA_R       <= visible ? Red_in   : '0;
        VGA_G       <= visible ? Green_in : '0;
        VGA_B       <= visible ? Blue_in  : '0;
        VGA_HS      <= hs_raw;
        VGA_VS      <= vs_raw;
        VGA_BLANK_N <= visible;
      end
    end
  end

  assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance for line-level timing
// and a scaled-down instance (CLK_DIV = 4) for whole-frame behaviour.
module tb_vga_timing_gen;

  typedef struct {
    int unsigned hv, hfp, hsy, hbp, vv, vfp, vsy, vbp, cd;
  } cfg_t;

  typedef struct {
    int unsigned at;
    int unsigned dx, dy;
    bit          hs, bn;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  r_in[2], g_in[2], b_in[2];
  logic [10:0] dx[2], dy[2];
  logic [7:0]  vr[2], vg[2], vb[2];
  logic        hs[2], vs[2], bn[2], sn[2], vck[2], tk[2];

  vga_timing_gen u_full (
    .Clk(clk), .Reset_n(rst_n),
    .Red_in(r_in[0]), .Green_in(g_in[0]), .Blue_in(b_in[0]),
    .DrawX(dx[0]), .DrawY(dy[0]),
    .VGA_R(vr[0]), .VGA_G(vg[0]), .VGA_B(vb[0]),
    .VGA_HS(hs[0]), .VGA_VS(vs[0]), .VGA_BLANK_N(bn[0]), .VGA_SYNC_N(sn[0]),
    .VGA_CLK(vck[0]), .frame_tick(tk[0])
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VISIBLE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(4)
  ) u_small (
    .Clk(clk), .Reset_n(rst_n),
    .Red_in(r_in[1]), .Green_in(g_in[1]), .Blue_in(b_in[1]),
    .DrawX(dx[1]), .DrawY(dy[1]),
    .VGA_R(vr[1]), .VGA_G(vg[1]), .VGA_B(vb[1]),
    .VGA_HS(hs[1]), .VGA_VS(vs[1]), .VGA_BLANK_N(bn[1]), .VGA_SYNC_N(sn[1]),
    .VGA_CLK(vck[1]), .frame_tick(tk[1])
  );

  cfg_t        cfg[2];
  vec_t        vecs[11];
  int unsigned t;          // rising edges since the last reset release
  bit          in_rst;
  bit          fb_mode;    // Red_in follows DrawX[7:0]
  logic [7:0]  pend_r[2], pend_g[2], pend_b[2];
  bit          pend_fb[2];
  logic [7:0]  m_r[2], m_g[2], m_b[2];
  int unsigned n_vec, n_miss;
  int unsigned hs_low[2];
  int unsigned vs_low;
  int unsigned tick_q[$];

  function automatic int unsigned htot(cfg_t c);
    return c.hv + c.hfp + c.hsy + c.hbp;
  endfunction

  function automatic int unsigned vtot(cfg_t c);
    return c.vv + c.vfp + c.vsy + c.vbp;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at t=%0d: got %0h, required %0h", nm, t, act, exp);
    end
  endtask

  // Reference: output state derived purely from the edge count since release.
  task automatic check_outputs(input int i);
    cfg_t c;
    int unsigned ht, vt, n, p, x, y, e_dx, e_dy;
    bit e_hs, e_vs, e_bn, e_tk, e_ck;
    string pre;
    c = cfg[i];
    pre = (i == 0) ? "full" : "small";
    ht = htot(c); vt = vtot(c);
    n = t / c.cd;
    e_dx = n % ht;
    e_dy = (n / ht) % vt;
    e_hs = 1'b1; e_vs = 1'b1; e_bn = 1'b0; e_tk = 1'b0;
    if (n > 0) begin
      p = n - 1;
      x = p % ht;
      y = (p / ht) % vt;
      e_hs = !((x >= c.hv + c.hfp) && (x < c.hv + c.hfp + c.hsy));
      e_vs = !((y >= c.vv + c.vfp) && (y < c.vv + c.vfp + c.vsy));
      e_bn = (x < c.hv) && (y < c.vv);
      e_tk = (t % c.cd == 0) && (x == c.hv - 1) && (y == c.vv - 1);
    end
    e_ck = (t % c.cd) >= (c.cd / 2);
    chk({pre, " DrawX"},       32'(dx[i]),  e_dx);
    chk({pre, " DrawY"},       32'(dy[i]),  e_dy);
    chk({pre, " VGA_R"},       32'(vr[i]),  32'(m_r[i]));
    chk({pre, " VGA_G"},       32'(vg[i]),  32'(m_g[i]));
    chk({pre, " VGA_B"},       32'(vb[i]),  32'(m_b[i]));
    chk({pre, " VGA_HS"},      32'(hs[i]),  32'(e_hs));
    chk({pre, " VGA_VS"},      32'(vs[i]),  32'(e_vs));
    chk({pre, " VGA_BLANK_N"}, 32'(bn[i]),  32'(e_bn));
    chk({pre, " VGA_SYNC_N"},  32'(sn[i]),  32'd0);
    chk({pre, " VGA_CLK"},     32'(vck[i]), 32'(e_ck));
    chk({pre, " frame_tick"},  32'(tk[i]),  32'(e_tk));
  endtask

  task automatic step();
    int unsigned p, x, ht, vt;
    @(posedge clk);
    if (!in_rst) begin
      t++;
      for (int i = 0; i < 2; i++) begin
        if (t % cfg[i].cd == 0) begin
          ht = htot(cfg[i]); vt = vtot(cfg[i]);
          p = t / cfg[i].cd - 1;
          x = p % ht;
          if ((x < cfg[i].hv) && (((p / ht) % vt) < cfg[i].vv)) begin
            m_r[i] = pend_fb[i] ? 8'(x) : pend_r[i];
            m_g[i] = pend_g[i];
            m_b[i] = pend_b[i];
          end else begin
            m_r[i] = '0; m_g[i] = '0; m_b[i] = '0;
          end
        end
      end
    end
    @(negedge clk);
    check_outputs(0);
    check_outputs(1);
    if (!in_rst) begin
      if (tk[1] === 1'b1) tick_q.push_back(t);
      if (t >= 1 && t <= 3200 && hs[0] === 1'b0) hs_low[(t - 1) / 1600]++;
      if (t >= 1 && t <= 1300 && vs[1] === 1'b0) vs_low++;
    end
    for (int i = 0; i < 2; i++) begin
      r_in[i] = in_rst ? 8'hFF : (fb_mode ? dx[i][7:0] : 8'($urandom));
      g_in[i] = 8'($urandom);
      b_in[i] = 8'($urandom);
      if (!in_rst && ((t + 1) % cfg[i].cd == 0)) begin
        pend_r[i]  = r_in[i];
        pend_g[i]  = g_in[i];
        pend_b[i]  = b_in[i];
        pend_fb[i] = fb_mode;
      end
    end
  endtask

  // Assert reset away from a clock edge and confirm it acts without one.
  task automatic do_reset(input int unsigned cycles);
    rst_n  = 1'b0;
    in_rst = 1'b1;
    t      = 0;
    for (int i = 0; i < 2; i++) begin
      m_r[i] = '0; m_g[i] = '0; m_b[i] = '0;
    end
    #1;
    check_outputs(0);
    check_outputs(1);
    repeat (cycles) step();
    rst_n  = 1'b1;
    in_rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned first_tick, frame_len, guard;
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
    cfg[1] = '{16, 2, 4, 3, 8, 1, 2, 2, 4};
    //          at    DrawX DrawY HS BLANK_N
    vecs[0]  = '{1,    0,   0,    1, 0};
    vecs[1]  = '{2,    1,   0,    1, 1};
    vecs[2]  = '{1280, 640, 0,    1, 1};
    vecs[3]  = '{1282, 641, 0,    1, 0};
    vecs[4]  = '{1312, 656, 0,    1, 0};
    vecs[5]  = '{1314, 657, 0,    0, 0};
    vecs[6]  = '{1504, 752, 0,    0, 0};
    vecs[7]  = '{1506, 753, 0,    1, 0};
    vecs[8]  = '{1598, 799, 0,    1, 0};
    vecs[9]  = '{1600, 0,   1,    1, 0};
    vecs[10] = '{1602, 1,   1,    1, 1};
    n_vec = 0; n_miss = 0; t = 0; in_rst = 1'b0; fb_mode = 1'b0;
    hs_low[0] = 0; hs_low[1] = 0; vs_low = 0;
    for (int i = 0; i < 2; i++) begin
      r_in[i] = 8'hFF; g_in[i] = '0; b_in[i] = '0;
      pend_r[i] = '0; pend_g[i] = '0; pend_b[i] = '0; pend_fb[i] = 1'b0;
      m_r[i] = '0; m_g[i] = '0; m_b[i] = '0;
    end
    rst_n = 1'b1;
    #1;
    do_reset(5);

    for (int k = 0; k < 11; k++) begin
      while (t < vecs[k].at) step();
      chk("table DrawX",       32'(dx[0]), vecs[k].dx);
      chk("table DrawY",       32'(dy[0]), vecs[k].dy);
      chk("table VGA_HS",      32'(hs[0]), 32'(vecs[k].hs));
      chk("table VGA_BLANK_N", 32'(bn[0]), 32'(vecs[k].bn));
    end

    while (t < 3400) step();
    chk("hs low cycles line 0", hs_low[0], 96 * 2);
    chk("hs low cycles line 1", hs_low[1], 96 * 2);
    chk("small vs low cycles", vs_low, cfg[1].vsy * htot(cfg[1]) * cfg[1].cd);

    first_tick = cfg[1].cd * ((cfg[1].vv - 1) * htot(cfg[1]) + cfg[1].hv);
    frame_len  = htot(cfg[1]) * vtot(cfg[1]) * cfg[1].cd;
    chk("small tick count", tick_q.size(), 3);
    for (int k = 0; k < tick_q.size(); k++)
      chk("small tick time", tick_q[k], first_tick + k * frame_len);

    fb_mode = 1'b1;
    while (t < 4800) step();
    fb_mode = 1'b0;

    guard = 0;
    while (dy[1] !== 11'd4 && guard < 2000) begin
      step();
      guard++;
    end
    chk("mid-frame line reached", 32'(dy[1]), 4);
    repeat (10) step();
    tick_q.delete();
    do_reset(3);
    while (t < 1400) step();
    chk("post-reset tick count", tick_q.size(), 1);
    if (tick_q.size() > 0) chk("post-reset tick time", tick_q[0], first_tick);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
